mem_fill_arbiter: RTL and testbench
===================================

# mem_fill_arbiter

Arbitrates the single main-memory port between I-cache miss fills, D-cache miss fills and D-cache write-through stores. The block sits between the two caches and main memory. On a miss it streams a whole cache block from a pipelined fixed-latency memory and steers each returned word into the requesting cache. The IF stage stalls on `i_busy`, and MEM stalls on `d_busy`.

## Interface
- `BLOCK_WORDS`, default 8: 16-bit words per cache block; power of two.
- `MEM_LATENCY`, default 4: cycles from a read issue to its `mem_valid`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  I-cache miss; held high until `i_done`.
- `i_addr`  in  16  I-cache miss byte address.
- `d_req`  in  1  D-cache request (miss fill or store); held high until `d_done`.
- `d_wr`  in  1  qualifies `d_req`: 1 = single-word store, 0 = block fill.
- `d_addr`  in  16  D-cache byte address.
- `d_wdata`  in  16  store data.
- `mem_en`  out  1  memory access strobe.
- `mem_wr`  out  1  memory write when `mem_en`.
- `mem_addr`  out  16  memory byte address.
- `mem_wdata`  out  16  memory write data.
- `mem_rdata`  in  16  memory read data.
- `mem_valid`  in  1  `mem_rdata` valid.
- `fill_we`  out  1  write one fill word into the selected cache.
- `fill_sel`  out  1  0 = I-cache, 1 = D-cache.
- `fill_idx`  out  log2(BLOCK_WORDS)  word index within the block.
- `fill_data`  out  16  equals `mem_rdata`.
- `i_busy`, `d_busy`  out  1  request pending and not yet done; combinational from `*_req` and `*_done`.
- `i_done`, `d_done`  out  1  one-cycle completion pulse.

## Operation
- FSM states are IDLE, FILL and WRITE. Reset puts the FSM in IDLE and clears all counters, `last_d` and `grant`.
- **Reset values.** All outputs are 0 while in reset and in IDLE. The exceptions are `i_busy` and `d_busy`, which follow their requests.
- **Arbitration.** Requests are sampled only in IDLE.
  - If only one request is high, that request wins.
  - If both are high, D wins unless `last_d` = 1. In that case I wins, so D cannot starve I.
  - `last_d` is set when a D grant completes and cleared when an I grant completes.
- **Latched grant.** `grant`, the block base address and `d_wr` are latched at grant time. The base address is `addr & ~(2*BLOCK_WORDS-1)`.
- **WRITE** (D grant with `d_wr` = 1):
  - Lasts one cycle.
  - `mem_en` = `mem_wr` = 1, `mem_addr` = `d_addr`, `mem_wdata` = `d_wdata`.
  - `d_done` = 1 in the same cycle, then the FSM returns to IDLE.
- **FILL**:
  - `issue_cnt` runs from 0 to BLOCK_WORDS-1. While `issue_cnt` < BLOCK_WORDS, the block asserts `mem_en` = 1, `mem_wr` = 0 and `mem_addr` = base + 2·`issue_cnt`, and increments `issue_cnt` each cycle. This is one issue per cycle with no bubbles.
  - `ret_cnt` increments on each `mem_valid`. On each `mem_valid`: `fill_we` = 1, `fill_idx` = `ret_cnt`, `fill_sel` = `grant`.
  - When `mem_valid` arrives with `ret_cnt` = BLOCK_WORDS-1, the matching `*_done` pulses in that same cycle and the FSM goes to IDLE.
- `mem_valid` outside FILL is ignored: no `fill_we`.
- Widths: counters are log2(BLOCK_WORDS)+1 bits. Address arithmetic is 16-bit modulo; a block at 0xFFF0 stays in 0xFFF0–0xFFFE.

## Timing
- **Fill latency.** Request high in IDLE at cycle 0.
  - Issues occur in cycles 1..BLOCK_WORDS.
  - Returns occur in cycles 1+MEM_LATENCY..BLOCK_WORDS+MEM_LATENCY.
  - `done` is in cycle BLOCK_WORDS+MEM_LATENCY; with the defaults that is cycle 12.
- **Store latency.** Grant at cycle 0, write and `d_done` in cycle 1.
- **Back-to-back requests.** The next grant is sampled the cycle after `done`. A requester deasserts `req` in response to `done`, so the IDLE cycle after `done` sees the updated request.
- **Simultaneous new request during a grant.** The other requester's request is held (busy = 1) and evaluated at the next IDLE.
- **Reset mid-FILL.** The FSM returns to IDLE immediately and drives no further `fill_we`. The system holds `rst` for at least MEM_LATENCY cycles so in-flight returns drain while in IDLE.

## Structure
- Shared header `mem_arb_defs.vh` holds:
  - state encodings `ST_IDLE`, `ST_FILL`, `ST_WRITE`;
  - `SEL_I` / `SEL_D`;
  - default `BLOCK_WORDS` / `MEM_LATENCY`.
- State, counters, `grant`, `last_d` and the base address use the codebase `dff` cells.
- One sub-module, `burst_counter`, used twice (issue and return): synchronous clear and increment-enable, terminal-count output.

## Test plan
- **I fill.** `i_req` = 1, `i_addr` = 0x1236.
  - `mem_addr` is 0x1230, 0x1232 … 0x123E in cycles 1–8.
  - `fill_sel` = 0 and `fill_idx` runs 0–7 in cycles 5–12.
  - `i_done` pulses in cycle 12.
- **Store.** `d_req` = `d_wr` = 1, `d_addr` = 0x0040, `d_wdata` = 0xBEEF.
  - Cycle 1: `mem_en` = `mem_wr` = 1, `mem_addr` = 0x0040, `mem_wdata` = 0xBEEF, `d_done` = 1.
- **Contention.** `i_req` and `d_req` (fill) rise together.
  - D fill completes first (`d_done` at cycle 12), then the I fill is granted, even though `d_req` is re-raised in the IDLE cycle.
- **Wrap.** `d_addr` = 0xFFFA fill: issues run 0xFFF0..0xFFFE and never 0x0000.
- **Reset mid-fill.** Assert `rst` in cycle 6 of an I fill for 4 cycles.
  - No `fill_we` and no `i_done` from that cycle on.
  - A fresh request afterwards completes normally.
- **Stray `mem_valid` in IDLE.** Drive `mem_valid` = 1 with no request: `fill_we` stays 0 and the state stays IDLE.

Source files
------------

// File: rtl/mem_fill_arbiter_pkg.sv
// Shared types and defaults for the memory fill arbiter: FSM states, fill
// target select and the block-base helper.
package mem_fill_arbiter_pkg;

    localparam int DEF_BLOCK_WORDS = 8;
    localparam int DEF_MEM_LATENCY = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    typedef enum logic {
        SEL_I = 1'b0,
        SEL_D = 1'b1
    } sel_t;

    // Byte address of the first word of the block containing addr.
    function automatic logic [15:0] block_base(input logic [15:0] addr, input int words);
        return addr & ~16'(2 * words - 1);
    endfunction

endpackage

// File: rtl/mem_fill_arbiter_burst_counter.sv
// Burst word counter: synchronous clear, increment enable and a terminal-count
// flag that is high while the count equals LIMIT.
module burst_counter
    import mem_fill_arbiter_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: give every always_comb output a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_fill_arbiter.sv
// Shares one main-memory port between I-cache fills, D-cache fills and D-cache
// write-through stores; streams whole blocks from a pipelined memory.
module mem_fill_arbiter
    import mem_fill_arbiter_pkg::*;
#(
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY,
    localparam int IDX_W = $clog2(BLOCK_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [15:0]      i_addr,
    input  logic             d_req,
    input  logic             d_wr,
    input  logic [15:0]      d_addr,
    input  logic [15:0]      d_wdata,
    output logic             mem_en,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_valid,
    output logic             fill_we,
    output logic             fill_sel,
    output logic [IDX_W-1:0] fill_idx,
    output logic [15:0]      fill_data,
    output logic             i_busy,
    output logic             d_busy,
    output logic             i_done,
    output logic             d_done
);

    localparam int CNT_W = IDX_W + 1;
    localparam int EARLY = (MEM_LATENCY < BLOCK_WORDS) ? MEM_LATENCY : BLOCK_WORDS;

    state_t      state_q, state_d;
    sel_t        grant_q, grant_d;
    logic        last_d_q, last_d_d;
    logic [15:0] base_q, base_d;

    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic             issue_tc;
    logic             ret_tc;
    logic             in_fill;
    logic             issuing;
    logic             ret_last;
    logic             pick_d;

    assign in_fill  = (state_q == ST_FILL);
    assign issuing  = in_fill & ~issue_tc;
    assign ret_last = in_fill & mem_valid & ret_tc;
    // D wins a tie unless it took the previous grant, so I cannot starve.
    assign pick_d   = d_req & (~i_req | ~last_d_q);

    burst_counter #(.CNT_W(CNT_W), .LIMIT(BLOCK_WORDS)) u_issue_cnt (
        .clk (clk),
        .rst (rst),
        .clr (~in_fill),
        .inc (issuing),
        .cnt (issue_cnt),
        .tc  (issue_tc)
    );

    burst_counter #(.CNT_W(CNT_W), .LIMIT(BLOCK_WORDS - 1)) u_ret_cnt (
        .clk (clk),
        .rst (rst),
        .clr (~in_fill),
        .inc (in_fill & mem_valid),
        .cnt (ret_cnt),
        .tc  (ret_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= SEL_I;
            last_d_q <= 1'b0;
            base_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_d_q <= last_d_d;
            base_q   <= base_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d_d = last_d_q;
        base_d   = base_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req | d_req) begin
                    grant_d = pick_d ? SEL_D : SEL_I;
                    base_d  = block_base(pick_d ? d_addr : i_addr, BLOCK_WORDS);
                    state_d = (pick_d & d_wr) ? ST_WRITE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (ret_last) begin
                    state_d  = ST_IDLE;
                    last_d_d = (grant_q == SEL_D);
                end
            end
            ST_WRITE: begin
                state_d  = ST_IDLE;
                last_d_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_we   = 1'b0;
        fill_sel  = 1'b0;
        fill_idx  = '0;
        fill_data = '0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        case (state_q)
            ST_FILL: begin
                mem_en = issuing;
                if (issuing) begin
                    mem_addr = base_q + (16'(issue_cnt) << 1);
                end
                if (mem_valid) begin
                    fill_we   = 1'b1;
                    fill_sel  = (grant_q == SEL_D);
                    fill_idx  = IDX_W'(ret_cnt);
                    fill_data = mem_rdata;
                end
                i_done = ret_last & (grant_q == SEL_I);
                d_done = ret_last & (grant_q == SEL_D);
            end
            ST_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign i_busy = i_req & ~i_done;
    assign d_busy = d_req & ~d_done;

    // A read can only return once the first MEM_LATENCY issues have gone out.
    always @(posedge clk) begin
        if (!rst && in_fill && mem_valid) begin
            assert (int'(issue_cnt) >= EARLY);
        end
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Randomised scoreboard bench for mem_fill_arbiter: a transaction-level model
// predicts every memory access, fill word and done pulse with its cycle.
module tb_mem_fill_arbiter;
    import mem_fill_arbiter_pkg::*;

    localparam int BW  = 8;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic        fill_we, fill_sel;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        i_busy, d_busy, i_done, d_done;

    mem_fill_arbiter #(.BLOCK_WORDS(BW), .MEM_LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .fill_we   (fill_we),
        .fill_sel  (fill_sel),
        .fill_idx  (fill_idx),
        .fill_data (fill_data),
        .i_busy    (i_busy),
        .d_busy    (d_busy),
        .i_done    (i_done),
        .d_done    (d_done)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [15:0] addr; } issue_t;
    typedef struct { int cyc; logic sel; int idx; logic [15:0] data; } fill_t;
    typedef struct { int cyc; logic [15:0] addr; logic [15:0] data; } store_t;
    typedef struct { int cyc; logic sel; } done_t;
    typedef struct { int due; logic [15:0] addr; } rd_t;
    typedef struct { bit en; bit wr; logic [15:0] addr; logic [15:0] data; } op_t;

    issue_t issue_q[$];
    fill_t  fill_q[$];
    store_t store_q[$];
    done_t  done_q[$];
    rd_t    rd_q[$];

    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    bit stray = 1'b0;
    bit m_last_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endtask

    // ---------------- memory device: fixed-latency pipelined reads ----------
    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin : mem_drive
        logic [15:0] a;
        #1;
        if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
            a = rd_q[0].addr;
            rd_q.pop_front();
            mem_valid = 1'b1;
            mem_rdata = mem[a[15:1]];
        end else begin
            mem_valid = stray;
            mem_rdata = 16'($urandom);
        end
    end

    // ---------------- monitor / scoreboard ----------------------------------
    always @(negedge clk) begin : mon
        bit e_iss, e_st, e_fill, e_id, e_dd;
        issue_t ih;
        fill_t  fh;
        store_t sh;
        logic [15:0] a;
        e_iss  = issue_q.size() != 0 && issue_q[0].cyc == cyc;
        e_st   = store_q.size() != 0 && store_q[0].cyc == cyc;
        e_fill = fill_q.size()  != 0 && fill_q[0].cyc  == cyc;
        e_id   = done_q.size()  != 0 && done_q[0].cyc  == cyc && done_q[0].sel == 1'b0;
        e_dd   = done_q.size()  != 0 && done_q[0].cyc  == cyc && done_q[0].sel == 1'b1;

        check("mem_en",  mem_en,  e_iss || e_st);
        check("mem_wr",  mem_wr,  e_st);
        check("fill_we", fill_we, e_fill);
        check("i_done",  i_done,  e_id);
        check("d_done",  d_done,  e_dd);
        check("i_busy",  i_busy,  i_req && !e_id);
        check("d_busy",  d_busy,  d_req && !e_dd);

        if (rst === 1'b1) begin
            check("rst_mem_addr",  mem_addr,  0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_fill_data", fill_data, 0);
            check("rst_fill_idx",  fill_idx,  0);
            check("rst_fill_sel",  fill_sel,  0);
        end
        if (e_iss) begin
            ih = issue_q.pop_front();
            check("issue_addr", mem_addr, ih.addr);
        end
        if (e_st) begin
            sh = store_q.pop_front();
            check("store_addr",  mem_addr,  sh.addr);
            check("store_wdata", mem_wdata, sh.data);
        end
        if (e_fill) begin
            fh = fill_q.pop_front();
            check("fill_sel",  fill_sel,  fh.sel);
            check("fill_idx",  fill_idx,  fh.idx);
            check("fill_data", fill_data, fh.data);
        end
        if (e_id || e_dd) done_q.pop_front();

        // memory device side effects
        if (mem_en === 1'b1 && mem_wr === 1'b0) rd_q.push_back('{cyc + LAT, mem_addr});
        if (mem_en === 1'b1 && mem_wr === 1'b1) begin
            a = mem_addr;
            mem[a[15:1]] = mem_wdata;
        end
    end

    // ---------------- transaction-level reference model ---------------------
    function automatic logic [15:0] base_of(input logic [15:0] a);
        return a - 16'(a % 16'(2 * BW));
    endfunction

    task automatic model_fill(input int s, input logic sel, input logic [15:0] addr,
                              input int abort, output int done_cyc);
        logic [15:0] b;
        logic [15:0] wa;
        b = base_of(addr);
        for (int k = 0; k < BW; k++) begin
            wa = b + 16'(2 * k);
            if (s + 1 + k < abort) issue_q.push_back('{s + 1 + k, wa});
            if (s + 1 + LAT + k < abort) fill_q.push_back('{s + 1 + LAT + k, sel, k, ref_mem[wa[15:1]]});
        end
        done_cyc = s + BW + LAT;
        if (done_cyc < abort) done_q.push_back('{done_cyc, sel});
    endtask

    task automatic model_store(input int s, input logic [15:0] addr, input logic [15:0] data,
                               output int done_cyc);
        store_q.push_back('{s + 1, addr, data});
        ref_mem[addr[15:1]] = data;
        done_cyc = s + 1;
        done_q.push_back('{done_cyc, 1'b1});
    endtask

    // Grants in order: a tie goes to D unless D took the last grant; a second
    // D request appears in the idle cycle right after the first D completes.
    task automatic model_episode(input int s0, input op_t iop, input op_t dop,
                                 input op_t dop2, input int abort);
        int  t;
        int  dc;
        bit  ip, dp, d2;
        op_t cur;
        t = s0; ip = iop.en; dp = dop.en; d2 = dop2.en; cur = dop;
        while (ip || dp) begin
            if (dp && (!ip || !m_last_d)) begin
                if (cur.wr) model_store(t, cur.addr, cur.data, dc);
                else        model_fill(t, 1'b1, cur.addr, abort, dc);
                m_last_d = 1'b1;
                dp = 1'b0;
                if (d2) begin cur = dop2; dp = 1'b1; d2 = 1'b0; end
            end else begin
                model_fill(t, 1'b0, iop.addr, abort, dc);
                m_last_d = 1'b0;
                ip = 1'b0;
            end
            t = dc + 1;
        end
    endtask

    // ---------------- stimulus ----------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit side, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if ((side ? d_done : i_done) === 1'b1) ok = 1'b1;
        end
        check(side ? "d_done_seen" : "i_done_seen", ok, 1);
    endtask

    task automatic drive_d(input op_t o);
        d_req = 1'b1; d_wr = o.wr; d_addr = o.addr; d_wdata = o.data;
    endtask

    task automatic drain_check();
        repeat (3) next_cycle();
        check("queues_drained", issue_q.size() + fill_q.size() + store_q.size() + done_q.size(), 0);
    endtask

    task automatic run_episode(input op_t iop, input op_t dop, input op_t dop2);
        int s0;
        next_cycle();
        s0 = cyc;
        model_episode(s0, iop, dop, dop2, 32'h7fffffff);
        if (iop.en) begin i_req = 1'b1; i_addr = iop.addr; end
        if (dop.en) drive_d(dop);
        fork
            begin
                bit ok_i;
                if (iop.en) begin
                    wait_done(1'b0, ok_i);
                    next_cycle();
                    i_req = 1'b0;
                end
            end
            begin
                bit ok_d;
                if (dop.en) begin
                    wait_done(1'b1, ok_d);
                    next_cycle();
                    if (dop2.en) begin
                        drive_d(dop2);
                        wait_done(1'b1, ok_d);
                        next_cycle();
                    end
                    d_req = 1'b0;
                end
            end
        join
        drain_check();
    endtask

    function automatic op_t mk(input bit en, input bit wr, input logic [15:0] a, input logic [15:0] d);
        op_t o;
        o.en = en; o.wr = wr; o.addr = a; o.data = d;
        return o;
    endfunction

    function automatic op_t rand_op(input bit allow_wr);
        op_t o;
        o.en   = 1'b1;
        o.wr   = allow_wr && ($urandom_range(0, 2) == 0);
        o.addr = ($urandom_range(0, 1) == 0) ? {8'h12, 8'($urandom)} : 16'($urandom);
        o.data = 16'($urandom);
        return o;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        op_t none, iop, dop, dop2;
        int  s0;
        none = mk(1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end

        // Reset: outputs quiet, busy still follows the request.
        i_req = 1'b1;
        repeat (2) next_cycle();
        check("rst_i_busy", i_busy, 1);
        check("rst_mem_en", mem_en, 0);
        i_req = 1'b0;
        next_cycle();
        rst = 1'b0;
        m_last_d = 1'b0;
        next_cycle();
        check("idle_mem_en", mem_en, 0);
        check("idle_fill_we", fill_we, 0);

        // Store, I fill, then contention with D re-raised in the idle cycle.
        run_episode(none, mk(1'b1, 1'b1, 16'h0040, 16'hBEEF), none);
        run_episode(mk(1'b1, 1'b0, 16'h1236, 16'h0), none, none);
        run_episode(mk(1'b1, 1'b0, 16'h2468, 16'h0), mk(1'b1, 1'b0, 16'h3002, 16'h0),
                    mk(1'b1, 1'b0, 16'h4010, 16'h0));

        // Fill of the top block must not wrap past 0xFFFE.
        run_episode(none, mk(1'b1, 1'b0, 16'hFFFA, 16'h0), none);

        // Stray mem_valid while idle.
        @(negedge clk);
        stray = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        stray = 1'b0;
        run_episode(mk(1'b1, 1'b0, 16'h0A0C, 16'h0), none, none);

        // Reset in cycle 6 of an I fill, held 4 cycles, then a fresh fill.
        next_cycle();
        s0 = cyc;
        model_episode(s0, mk(1'b1, 1'b0, 16'h5556, 16'h0), none, none, s0 + 6);
        i_req = 1'b1;
        i_addr = 16'h5556;
        repeat (6) next_cycle();
        rst = 1'b1;
        i_req = 1'b0;
        m_last_d = 1'b0;
        repeat (4) next_cycle();
        rst = 1'b0;
        drain_check();
        run_episode(mk(1'b1, 1'b0, 16'h5556, 16'h0), none, none);

        // Randomised mix of fills, stores and contention.
        for (int n = 0; n < 40; n++) begin
            iop = none;
            dop = none;
            dop2 = none;
            case ($urandom_range(0, 2))
                0: iop = rand_op(1'b0);
                1: dop = rand_op(1'b1);
                default: begin iop = rand_op(1'b0); dop = rand_op(1'b1); end
            endcase
            if (dop.en && $urandom_range(0, 3) == 0) dop2 = rand_op(1'b1);
            run_episode(iop, dop, dop2);
        end

        repeat (3) next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
